// File: rtl/beep_pkg.sv
// Shared mode encodings, default timing constants and counter sizing helper
// for the beep pattern generator.
package beep_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_CONT  = 2'd1,
    MODE_PULSE = 2'd2,
    MODE_ALARM = 2'd3
  } mode_e;

  localparam int unsigned DEF_TONE_A_HALF = 32'd25000;
  localparam int unsigned DEF_TONE_B_HALF = 32'd12500;
  localparam int unsigned DEF_GATE_MAX    = 32'd10000000;

  // Bits needed to count 0..max_v-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_v);
    return (max_v > 32'd1) ? $clog2(max_v) : 32'd1;
  endfunction

endpackage

// File: rtl/tone_div.sv
// Half-period counter: wraps at a selectable terminal value and toggles a
// phase register on each wrap; synchronous clear overrides enable.
module tone_div #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         phase
);

  logic [W-1:0] cnt_r;
  logic         phase_r;

  // Counter and phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {W{1'b0}};
      phase_r <= 1'b0;
    end else if (clr) begin
      cnt_r   <= {W{1'b0}};
      phase_r <= 1'b0;
    end else if (en) begin
      if (cnt_r == last) begin
        cnt_r   <= {W{1'b0}};
        phase_r <= ~phase_r;
      end else begin
        cnt_r   <= cnt_r + W'(1);
        phase_r <= phase_r;
      end
    end else begin
      cnt_r   <= cnt_r;
      phase_r <= phase_r;
    end
  end

  assign phase = phase_r;

endmodule

// File: rtl/beep_pattern_gen.sv
// Key-stepped buzzer pattern generator: OFF -> CONT -> PULSE -> ALARM -> OFF,
// with a gate interval switching the tone off (PULSE) or to tone B (ALARM).
module beep_pattern_gen
  import beep_pkg::*;
#(
  parameter int unsigned TONE_A_HALF = DEF_TONE_A_HALF,
  parameter int unsigned TONE_B_HALF = DEF_TONE_B_HALF,
  parameter int unsigned GATE_MAX    = DEF_GATE_MAX
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_filter,
  output logic       beep,
  output logic [1:0] mode
);

  localparam int unsigned TONE_MAX = (TONE_A_HALF > TONE_B_HALF) ? TONE_A_HALF : TONE_B_HALF;
  localparam int unsigned TONE_W   = cnt_width(TONE_MAX);
  localparam int unsigned GATE_W   = cnt_width(GATE_MAX);
  localparam logic [TONE_W-1:0] TONE_A_LAST = TONE_W'(TONE_A_HALF - 32'd1);
  localparam logic [TONE_W-1:0] TONE_B_LAST = TONE_W'(TONE_B_HALF - 32'd1);
  localparam logic [GATE_W-1:0] GATE_LAST   = GATE_W'(GATE_MAX - 32'd1);

  logic              key_d_r;
  logic              press_s;
  mode_e             mode_r;
  mode_e             mode_nxt_s;
  logic [GATE_W-1:0] gate_cnt_r;
  logic              gate_r;
  logic              gate_term_s;
  logic              gated_s;
  logic              tone_clr_s;
  logic              tone_en_s;
  logic [TONE_W-1:0] tone_last_s;
  logic              tone_phase_s;

  assign press_s     = key_filter & ~key_d_r;
  assign gate_term_s = (gate_cnt_r == GATE_LAST);
  assign gated_s     = (mode_r == MODE_PULSE) || (mode_r == MODE_ALARM);

  // Key delay register for rising-edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_d_r <= 1'b0;
    end else begin
      key_d_r <= key_filter;
    end
  end

  // Mode state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_r <= MODE_OFF;
    end else begin
      mode_r <= mode_nxt_s;
    end
  end

  // Mode next-state: one advance per detected press
  always_comb begin
    mode_nxt_s = mode_r;
    if (press_s) begin
      case (mode_r)
        MODE_OFF:   mode_nxt_s = MODE_CONT;
        MODE_CONT:  mode_nxt_s = MODE_PULSE;
        MODE_PULSE: mode_nxt_s = MODE_ALARM;
        MODE_ALARM: mode_nxt_s = MODE_OFF;
        default:    mode_nxt_s = MODE_OFF;
      endcase
    end else begin
      mode_nxt_s = mode_r;
    end
  end

  // Gate interval counter; a mode change restarts it with the gate open
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gate_cnt_r <= {GATE_W{1'b0}};
      gate_r     <= 1'b1;
    end else if (press_s || !gated_s) begin
      gate_cnt_r <= {GATE_W{1'b0}};
      gate_r     <= 1'b1;
    end else if (gate_term_s) begin
      gate_cnt_r <= {GATE_W{1'b0}};
      gate_r     <= ~gate_r;
    end else begin
      gate_cnt_r <= gate_cnt_r + GATE_W'(1);
      gate_r     <= gate_r;
    end
  end

  // Tone divider control; clearing on a gate toggle keeps each burst starting low
  always_comb begin
    tone_clr_s  = 1'b0;
    tone_en_s   = 1'b0;
    tone_last_s = TONE_A_LAST;
    if ((mode_r == MODE_ALARM) && !gate_r) begin
      tone_last_s = TONE_B_LAST;
    end else begin
      tone_last_s = TONE_A_LAST;
    end
    if (press_s) begin
      tone_clr_s = 1'b1;
    end else begin
      case (mode_r)
        MODE_OFF:   tone_clr_s = 1'b1;
        MODE_CONT:  tone_en_s  = 1'b1;
        MODE_PULSE: begin
          if (gate_term_s || !gate_r) begin
            tone_clr_s = 1'b1;
          end else begin
            tone_en_s = 1'b1;
          end
        end
        MODE_ALARM: begin
          if (gate_term_s) begin
            tone_clr_s = 1'b1;
          end else begin
            tone_en_s = 1'b1;
          end
        end
        default:    tone_clr_s = 1'b1;
      endcase
    end
  end

  tone_div #(
    .W (TONE_W)
  ) u_tone_div (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .clr   (tone_clr_s),
    .en    (tone_en_s),
    .last  (tone_last_s),
    .phase (tone_phase_s)
  );

  assign beep = tone_phase_s;
  assign mode = mode_r;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Table-driven bench for beep_pattern_gen with a per-cycle scoreboard fed by a
// behavioural waveform model (time since mode entry -> expected beep).
module tb_beep_pattern_gen;

  localparam int TA = 4;
  localparam int TB = 2;
  localparam int GM = 20;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_filter;
  logic       beep;
  logic [1:0] mode;

  beep_pattern_gen #(
    .TONE_A_HALF (TA),
    .TONE_B_HALF (TB),
    .GATE_MAX    (GM)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_filter (key_filter),
    .beep       (beep),
    .mode       (mode)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       key;
    int         cycles;
    logic [1:0] exp_mode;
  } vec_t;

  vec_t       vecs[17];
  logic [2:0] sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [1:0] m_mode;
  int         m_t;
  logic       m_keyd;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beep from mode and cycles elapsed since mode entry.
  function automatic logic exp_beep(input logic [1:0] md, input int t);
    int p;
    p = t % (2 * GM);
    case (md)
      2'd1:    return ((t / TA) % 2) == 1;
      2'd2:    return (p < GM) ? (((p / TA) % 2) == 1) : 1'b0;
      2'd3:    return (p < GM) ? (((p / TA) % 2) == 1) : ((((p - GM) / TB) % 2) == 1);
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive key, predict, wait for the edge, compare.
  task automatic step(input logic k);
    logic [2:0] exp;
    key_filter = k;
    if (k && !m_keyd) begin
      m_mode = m_mode + 2'd1;
      m_t    = 0;
    end else begin
      m_t = m_t + 1;
    end
    m_keyd = k;
    sb_q.push_back({m_mode, exp_beep(m_mode, m_t)});
    @(posedge sys_clk);
    #1;
    exp = sb_q.pop_front();
    check("mode", mode, exp[2:1]);
    check("beep", {1'b0, beep}, {1'b0, exp[0]});
  endtask

  initial begin
    vecs[0]  = '{1'b0, 100, 2'd0};
    vecs[1]  = '{1'b1, 10,  2'd1};
    vecs[2]  = '{1'b0, 40,  2'd1};
    vecs[3]  = '{1'b1, 1,   2'd2};
    vecs[4]  = '{1'b0, 85,  2'd2};
    vecs[5]  = '{1'b1, 1,   2'd3};
    vecs[6]  = '{1'b0, 85,  2'd3};
    vecs[7]  = '{1'b1, 1,   2'd0};
    vecs[8]  = '{1'b0, 20,  2'd0};
    vecs[9]  = '{1'b1, 1,   2'd1};
    vecs[10] = '{1'b0, 3,   2'd1};
    vecs[11] = '{1'b1, 1,   2'd2};
    vecs[12] = '{1'b0, 19,  2'd2};
    vecs[13] = '{1'b1, 1,   2'd3};
    vecs[14] = '{1'b0, 45,  2'd3};
    vecs[15] = '{1'b1, 2,   2'd0};
    vecs[16] = '{1'b0, 5,   2'd0};

    sys_rst_n  = 1'b0;
    key_filter = 1'b0;
    m_mode     = 2'd0;
    m_t        = 0;
    m_keyd     = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    check("reset_mode", mode, 2'd0);
    check("reset_beep", {1'b0, beep}, 2'd0);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      for (int c = 0; c < vecs[i].cycles; c++) begin
        step(vecs[i].key);
      end
      check($sformatf("vec%0d_mode", i), mode, vecs[i].exp_mode);
    end

    // Reach ALARM with beep high, then drop reset between edges.
    for (int n = 0; n < 4 && m_mode != 2'd3; n++) begin
      step(1'b1);
      step(1'b0);
    end
    repeat (5) step(1'b0);
    check("alarm_mode", mode, 2'd3);
    check("alarm_beep_hi", {1'b0, beep}, 2'd1);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_mode", mode, 2'd0);
    check("async_rst_beep", {1'b0, beep}, 2'd0);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    m_mode    = 2'd0;
    m_t       = 0;
    m_keyd    = 1'b0;

    repeat (10) step(1'b0);
    check("post_rst_off", mode, 2'd0);
    step(1'b1);
    check("post_rst_cont", mode, 2'd1);
    repeat (12) step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beep_pattern_gen.md
BEEP_PATTERN_GEN -- requirements
Module: beep_pattern_gen

Interface
REQ-001 SHALL have parameter TONE_A_HALF, default 25000, meaning tone A half-period in sys_clk cycles (1 kHz at 50 MHz).
REQ-002 SHALL have parameter TONE_B_HALF, default 12500, meaning tone B half-period in sys_clk cycles (2 kHz at 50 MHz).
REQ-003 SHALL have parameter GATE_MAX, default 10000000, meaning gate on/off interval in sys_clk cycles (200 ms).
REQ-004 SHALL have port sys_clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port sys_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port key_filter  input  1  debounced key press indication from upstream debouncer, active high.
REQ-007 SHALL have port beep  output  1  passive-buzzer drive, square wave, active high.
REQ-008 SHALL have port mode  output  2  current pattern mode (0 OFF, 1 CONT, 2 PULSE, 3 ALARM).

Function
REQ-009 SHALL register key_filter once (key_d) and detect a press as key_filter=1 and key_d=0.
REQ-010 SHALL advance the mode FSM on the clock edge where a press is sampled: OFF->CONT->PULSE->ALARM->OFF (wrap).
REQ-011 SHALL ignore key_filter held high across multiple cycles; one rising edge = exactly one advance.
REQ-012 SHALL, on every mode transition, clear tone counter, tone phase and gate counter, and set gate=1, in the same edge.
REQ-013 SHALL drive beep directly from the tone-phase register; no combinational path from inputs to beep.
REQ-014 OFF: tone phase and counters held 0; beep=0.
REQ-015 CONT: tone counter counts 0..TONE_A_HALF-1; at terminal count wraps to 0 and toggles phase; beep starts low for TONE_A_HALF cycles after entry, period 2*TONE_A_HALF.
REQ-016 PULSE: gate counter counts 0..GATE_MAX-1, toggles gate at terminal; gate=1 -> tone A as CONT; gate=0 -> tone counter and phase held 0 (beep low).
REQ-017 ALARM: gate counter as PULSE; gate=1 -> tone A, gate=0 -> tone B; on each gate toggle tone counter and phase cleared.
REQ-018 SHALL size counters to $clog2 of their maxima; terminal compare by equality only, no overflow.
REQ-019 SHALL reflect mode register on mode output with zero added latency (mode changes on same edge as FSM).
REQ-020 Press coincident with gate or tone terminal count: mode transition wins; REQ-012 clears apply.

Reset
REQ-021 SHALL, while sys_rst_n=0, asynchronously force mode=0, beep=0, key_d=0, all counters 0, phase 0, gate 1.
REQ-022 SHALL resume from OFF after reset release regardless of prior mode or mid-period counter state.

Structure
REQ-023 SHALL place mode encodings (OFF/CONT/PULSE/ALARM) and default TONE_A_HALF, TONE_B_HALF, GATE_MAX in shared package beep_pkg.
REQ-024 SHALL use one sub-module tone_div (half-period counter with clear, enable, selectable limit, phase toggle output), instantiated once.
REQ-025 SHALL sit directly downstream of the key debouncer, consuming its key_filter output, and drive the board beep pin.

Verification (bench parameters: TONE_A_HALF=4, TONE_B_HALF=2, GATE_MAX=20)
REQ-026 Reset held 5 cycles then released, no key -> mode=0, beep=0 for 100 cycles.
REQ-027 One 1-cycle key pulse -> mode=1 on that edge; beep low 4 cycles, high 4, repeating period 8.
REQ-028 key_filter held high 10 cycles -> mode advances exactly once (0->1).
REQ-029 Second press -> mode=2; beep period-8 square for 20 cycles, then low 20 cycles, repeating.
REQ-030 Third press -> mode=3; period-8 for 20 cycles, period-4 for 20 cycles; fourth press -> mode=0, beep=0 from that edge.
REQ-031 sys_rst_n dropped mid-ALARM with beep=1 -> beep=0 and mode=0 immediately (asynchronous), before next clock edge.
